// File: rtl/id_pipe_stage.sv
// Pipelined MIPS instruction-decode stage: field extraction, load-use bubble
// insertion and a valid/ready ID/EX register with flush.
module id_pipe_stage #(
  parameter int unsigned XLEN   = 32,
  parameter logic [4:0]  RA_REG = 5'd31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            regrt,
  input  logic            jal,
  input  logic [1:0]      imm_mode,
  output logic [4:0]      rd_addra,
  output logic [4:0]      rd_addrb,
  input  logic [XLEN-1:0] rf_douta,
  input  logic [XLEN-1:0] rf_doutb,
  input  logic            ex_valid,
  input  logic            ex_mtoreg,
  input  logic [4:0]      ex_wr_addr,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [4:0]      out_wr_addr,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_shamt,
  output logic [XLEN-1:0] out_jaddr,
  output logic [XLEN-1:0] out_opa,
  output logic [XLEN-1:0] out_opb,
  output logic [XLEN-1:0] out_pc,
  output logic            load_use
);

  logic [15:0]     w_imm16;
  logic [XLEN-1:0] w_zext;
  logic [XLEN-1:0] w_sext;
  logic [XLEN-1:0] w_imm;
  logic [4:0]      w_dest;
  logic            w_accept;

  logic            r_valid;
  logic [4:0]      r_wr_addr;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_shamt;
  logic [XLEN-1:0] r_jaddr;
  logic [XLEN-1:0] r_opa;
  logic [XLEN-1:0] r_opb;
  logic [XLEN-1:0] r_pc;

  assign rd_addra = in_inst[25:21];
  assign rd_addrb = in_inst[20:16];
  assign w_imm16  = in_inst[15:0];
  assign w_zext   = {{(XLEN-16){1'b0}}, w_imm16};
  assign w_sext   = {{(XLEN-16){w_imm16[15]}}, w_imm16};

  // Destination register select
  always_comb begin
    w_dest = in_inst[15:11];
    if (jal) begin
      w_dest = RA_REG;
    end else if (regrt) begin
      w_dest = in_inst[20:16];
    end else begin
      w_dest = in_inst[15:11];
    end
  end

  // Immediate extension; branch mode keeps the low XLEN bits after the shift
  always_comb begin
    w_imm = w_zext;
    case (imm_mode)
      2'b00:   w_imm = w_zext;
      2'b01:   w_imm = w_sext;
      2'b10:   w_imm = w_zext << 5'd16;
      2'b11:   w_imm = w_sext << 5'd2;
      default: w_imm = w_zext;
    endcase
  end

  // Hazard detection against a load in EX; $0 never stalls
  always_comb begin
    load_use = in_valid & ex_valid & ex_mtoreg & (ex_wr_addr != 5'd0) &
               ((ex_wr_addr == in_inst[25:21]) | (ex_wr_addr == in_inst[20:16]));
    in_ready = ~flush & ~load_use & (~r_valid | out_ready);
    w_accept = in_valid & in_ready;
  end

  // ID/EX register: reset, then flush, then accept, then drain, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_wr_addr <= 5'd0;
      r_imm     <= '0;
      r_shamt   <= '0;
      r_jaddr   <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_pc      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_wr_addr <= w_dest;
      r_imm     <= w_imm;
      r_shamt   <= {{(XLEN-5){1'b0}}, in_inst[10:6]};
      r_jaddr   <= {in_pc[XLEN-1:28], in_inst[25:0], 2'b00};
      r_opa     <= rf_douta;
      r_opb     <= rf_doutb;
      r_pc      <= in_pc;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign out_valid   = r_valid;
  assign out_wr_addr = r_wr_addr;
  assign out_imm     = r_imm;
  assign out_shamt   = r_shamt;
  assign out_jaddr   = r_jaddr;
  assign out_opa     = r_opa;
  assign out_opb     = r_opb;
  assign out_pc      = r_pc;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_id_pipe_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, regrt, jal, ex_valid, ex_mtoreg, flush, out_ready;
  logic        out_valid, load_use;
  logic [31:0] in_inst, in_pc, rf_douta, rf_doutb;
  logic [1:0]  imm_mode;
  logic [4:0]  rd_addra, rd_addrb, ex_wr_addr, out_wr_addr;
  logic [31:0] out_imm, out_shamt, out_jaddr, out_opa, out_opb, out_pc;

  int n_pass = 0;
  int n_total = 0;

  // behavioural model state
  logic        m_valid, m_zero;
  logic [4:0]  m_wr;
  logic [31:0] m_imm, m_shamt, m_jaddr, m_opa, m_opb, m_pc;

  id_pipe_stage #(.XLEN(32), .RA_REG(5'd31)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .regrt(regrt), .jal(jal),
    .imm_mode(imm_mode), .rd_addra(rd_addra), .rd_addrb(rd_addrb),
    .rf_douta(rf_douta), .rf_doutb(rf_doutb), .ex_valid(ex_valid),
    .ex_mtoreg(ex_mtoreg), .ex_wr_addr(ex_wr_addr), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_wr_addr(out_wr_addr),
    .out_imm(out_imm), .out_shamt(out_shamt), .out_jaddr(out_jaddr),
    .out_opa(out_opa), .out_opb(out_opb), .out_pc(out_pc), .load_use(load_use)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  function automatic logic [31:0] model_imm(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = imm[15] ? int'(imm) - 65536 : int'(imm);
    case (mode)
      2'd0:    return {16'h0, imm};
      2'd1:    return 32'(s);
      2'd2:    return 32'(int'(imm) * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  // One clock: check combinational outputs, advance model, check registers.
  task automatic step();
    logic exp_lu, exp_rdy;
    #1;
    exp_lu = in_valid && ex_valid && ex_mtoreg && (ex_wr_addr != 5'd0) &&
             ((ex_wr_addr == in_inst[25:21]) || (ex_wr_addr == in_inst[20:16]));
    exp_rdy = !flush && !exp_lu && (!m_valid || out_ready);
    chk("rd_addra", {27'd0, rd_addra}, {27'd0, in_inst[25:21]});
    chk("rd_addrb", {27'd0, rd_addrb}, {27'd0, in_inst[20:16]});
    chk("load_use", {31'd0, load_use}, {31'd0, exp_lu});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (rst) begin
      m_valid = 1'b0; m_zero = 1'b1; m_wr = 5'd0;
      m_imm = 32'd0; m_shamt = 32'd0; m_jaddr = 32'd0;
      m_opa = 32'd0; m_opb = 32'd0; m_pc = 32'd0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (in_valid && exp_rdy) begin
      m_valid = 1'b1; m_zero = 1'b0;
      m_wr    = jal ? 5'd31 : (regrt ? in_inst[20:16] : in_inst[15:11]);
      m_imm   = model_imm(in_inst[15:0], imm_mode);
      m_shamt = (in_inst >> 6) & 32'd31;
      m_jaddr = (in_pc & 32'hF000_0000) | ((in_inst & 32'h03FF_FFFF) * 32'd4);
      m_opa = rf_douta; m_opb = rf_doutb; m_pc = in_pc;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid || m_zero) begin
      chk("out_wr_addr", {27'd0, out_wr_addr}, {27'd0, m_wr});
      chk("out_imm", out_imm, m_imm);
      chk("out_shamt", out_shamt, m_shamt);
      chk("out_jaddr", out_jaddr, m_jaddr);
      chk("out_opa", out_opa, m_opa);
      chk("out_opb", out_opb, m_opb);
      chk("out_pc", out_pc, m_pc);
    end
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    regrt = 1'b0; jal = 1'b0; imm_mode = 2'd0; rf_douta = 32'd0; rf_doutb = 32'd0;
    ex_valid = 1'b0; ex_mtoreg = 1'b0; ex_wr_addr = 5'd0; out_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] held;
    idle();
    rst = 1'b1;
    m_valid = 1'b0; m_zero = 1'b1; m_wr = 5'd0;
    m_imm = 32'd0; m_shamt = 32'd0; m_jaddr = 32'd0;
    m_opa = 32'd0; m_opb = 32'd0; m_pc = 32'd0;
    @(posedge clk); #1;
    step();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_opa", out_opa, 32'd0);

    // basic decode: add $2,$4,$5
    idle(); in_valid = 1'b1; in_inst = 32'h0085_1020; rf_douta = 32'd7; rf_doutb = 32'd9;
    in_pc = 32'h0000_0104;
    step();
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_wr", {27'd0, out_wr_addr}, 32'd2);
    chk("basic_opa", out_opa, 32'd7);
    chk("basic_opb", out_opb, 32'd9);
    chk("basic_shamt", out_shamt, 32'd0);

    // immediate modes on 0x8001
    for (int m = 0; m < 4; m++) begin
      idle(); in_valid = 1'b1; in_inst = 32'h2000_8001; regrt = 1'b1; imm_mode = 2'(m);
      step();
      case (m)
        0:       chk("imm_zext", out_imm, 32'h0000_8001);
        1:       chk("imm_sext", out_imm, 32'hFFFF_8001);
        2:       chk("imm_upper", out_imm, 32'h8001_0000);
        default: chk("imm_branch", out_imm, 32'hFFFE_0004);
      endcase
    end

    // jal
    idle(); in_valid = 1'b1; in_inst = 32'h0C00_0010; in_pc = 32'h4000_0008; jal = 1'b1;
    step();
    chk("jal_wr", {27'd0, out_wr_addr}, 32'd31);
    chk("jal_jaddr", out_jaddr, 32'h4000_0040);

    // load-use on $4: one bubble, then accepted
    idle(); in_valid = 1'b1; in_inst = 32'h0085_1020; ex_valid = 1'b1; ex_mtoreg = 1'b1;
    ex_wr_addr = 5'd4; rf_douta = 32'd11;
    #1;
    chk("lu_flag", {31'd0, load_use}, 32'd1);
    chk("lu_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    ex_valid = 1'b0;
    step();
    chk("lu_accept", {31'd0, out_valid}, 32'd1);
    chk("lu_opa", out_opa, 32'd11);
    // ex_wr_addr = 0 with operand $0 never stalls
    idle(); in_valid = 1'b1; in_inst = 32'h0005_1020; ex_valid = 1'b1; ex_mtoreg = 1'b1;
    #1;
    chk("r0_no_stall", {31'd0, load_use}, 32'd0);
    step();

    // backpressure: 3 stalled cycles, then drain and load
    idle(); in_valid = 1'b1; in_inst = 32'h0085_1020; rf_douta = 32'hAAAA_0001;
    step();
    held = out_opa;
    in_inst = 32'h00A6_3820; rf_douta = 32'hBBBB_0002; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_opa_stable", out_opa, held);
    end
    out_ready = 1'b1;
    step();
    chk("bp_new_opa", out_opa, 32'hBBBB_0002);

    // flush with load_use pending
    idle(); in_valid = 1'b1; in_inst = 32'h0085_1020; ex_valid = 1'b1; ex_mtoreg = 1'b1;
    ex_wr_addr = 5'd5; flush = 1'b1;
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);

    // reset during a downstream stall
    idle(); in_valid = 1'b1; in_inst = 32'h0085_1020; rf_douta = 32'd5; in_pc = 32'h10;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_pc", out_pc, 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        in_inst[25:21] = 5'($urandom_range(0, 7));
        in_inst[20:16] = 5'($urandom_range(0, 7));
      end
      in_pc      = $urandom;
      regrt      = 1'($urandom_range(0, 1));
      jal        = ($urandom_range(0, 7) == 0);
      imm_mode   = 2'($urandom_range(0, 3));
      rf_douta   = $urandom;
      rf_doutb   = $urandom;
      ex_valid   = 1'($urandom_range(0, 1));
      ex_mtoreg  = 1'($urandom_range(0, 1));
      ex_wr_addr = 5'($urandom_range(0, 7));
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Pipelined, parametrised instruction-decode stage for the MIPS CPU, replacing the single-cycle decoder when the core moves to a 5-stage pipeline. It does the following:
- Extracts register addresses and immediate, shift and jump fields from the fetched instruction.
- Latches the decoded fields, register operands and PC into an ID/EX register behind a valid/ready handshake.
- Detects load-use hazards against the EX stage and inserts bubbles.
- Honours a flush from branch/jump resolution.

## Interface
- XLEN, 32: datapath width; must be ≥ 32; immediates, operands and PC are XLEN bits.
- RA_REG, 31: destination register written by jal.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch stage presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle (combinational).
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  PC+4 of the instruction.
- regrt  in  1  destination is inst[20:16] (else inst[15:11]).
- jal  in  1  destination forced to RA_REG.
- imm_mode  in  2  immediate extension select:
  - 00: zero-extend.
  - 01: sign-extend.
  - 10: upper (imm<<16, low 16 bits zero).
  - 11: sign-extend then <<2 (branch offset).
- rd_addra  out  5  regfile port A address = in_inst[25:21] (combinational).
- rd_addrb  out  5  regfile port B address = in_inst[20:16] (combinational).
- rf_douta, rf_doutb  in  XLEN  regfile read data, valid in the same cycle.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_mtoreg  in  1  EX instruction is a load.
- ex_wr_addr  in  5  EX destination register.
- flush  in  1  kill the instruction in this stage and the one being offered.
- out_ready  in  1  EX stage accepts the ID/EX contents.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_wr_addr  out  5  registered destination register.
- out_imm  out  XLEN  registered extended immediate.
- out_shamt  out  XLEN  registered {zeros, inst[10:6]}.
- out_jaddr  out  XLEN  registered {in_pc[XLEN-1:28], inst[25:0], 2'b00}.
- out_opa, out_opb  out  XLEN  registered rf_douta / rf_doutb.
- out_pc  out  XLEN  registered in_pc.
- load_use  out  1  hazard stall indicator (combinational).

## Operation
- **Destination select:** jal → RA_REG; otherwise regrt → inst[20:16]; otherwise inst[15:11]. There is no latch or hold path.
- **Load-use hazard:** `load_use = in_valid & ex_valid & ex_mtoreg & (ex_wr_addr != 0) & (ex_wr_addr == inst[25:21] | ex_wr_addr == inst[20:16])`.
- **Ready:** `in_ready = ~flush & ~load_use & (~out_valid | out_ready)`.
- **Register update priority, per rising edge:**
  - rst: all outputs are cleared.
  - else flush: out_valid←0; the data registers are don't-care and may hold.
  - else in_valid & in_ready: load all out_* fields and set out_valid←1.
  - else out_ready: out_valid←0. This covers the bubble inserted on load_use or on an empty input.
  - else: hold all registers (downstream stall).
- **Data-register gating:** data registers change only on an accepting edge. While out_valid & ~out_ready, every out_* field is stable.
- **Extension arithmetic:** done at XLEN. Sign extension replicates inst[15] up to bit XLEN-1. Mode 11 drops the top two bits of the sign-extended value after the shift.
- **Register 0:** register 0 never triggers a hazard, including the case where ex_wr_addr = 0 and an operand is $0.

## Timing
- **Reset:** out_valid=0; out_wr_addr=0; out_imm, out_shamt, out_jaddr, out_opa, out_opb, out_pc all zero.
- **Latency:** 1 cycle from accept edge to out_valid.
- **Throughput:** one instruction per cycle while out_ready=1 and there is no hazard.
- **Load-use:** costs exactly one bubble. The next cycle EX holds the bubble (ex_valid=0), load_use drops, and the instruction is accepted.
- **Flush + load_use, or flush + downstream stall in the same cycle:** flush wins; out_valid=0 after the edge.
- **Reset mid-stall:** the pending output is discarded and the stage is empty on the next cycle.
- **Handshake rule:** no combinational path from out_ready to any registered output. in_ready depends combinationally on out_ready, flush, in_inst and the ex_* inputs.

## Test plan
- **Basic decode:** reset, then inst 0x00851020 (add $2,$4,$5), regrt=0, rf_douta=7, rf_doutb=9, out_ready=1 → one cycle later out_valid=1, out_wr_addr=2, out_opa=7, out_opb=9, out_shamt=0.
- **Immediate modes on imm 0x8001, XLEN=32:**
  - mode 00 → 0x00008001.
  - mode 01 → 0xFFFF8001.
  - mode 10 → 0x80010000.
  - mode 11 → 0xFFFE0004.
- **jal:** inst 0x0C000010, in_pc=0x40000008 → out_wr_addr=31, out_jaddr=0x40000040.
- **Load-use:** ex_valid=1, ex_mtoreg=1, ex_wr_addr=4, next inst reads $4:
  - in_ready=0 and load_use=1 for one cycle; out_valid=0 for that cycle.
  - The instruction is accepted the following cycle.
  - Repeat with ex_wr_addr=0 → no stall.
- **Backpressure:** out_ready=0 for 3 cycles with out_valid=1 → all out_* stable, in_ready=0; out_ready=1 → next instruction loads on that edge.
- **Flush:** assert flush together with in_valid and load_use → out_valid=0 next cycle, input not consumed. Assert rst during a stall → all outputs zero next cycle.
